// File: rtl/icache_boot_loader_pkg.sv
// Shared definitions for the ICache boot loader: loader FSM encoding and
// program-size constants.
package icache_boot_loader_pkg;

    localparam int unsigned LDR_ADDR_W     = 10;
    localparam int unsigned LDR_DATA_W     = 32;
    localparam int unsigned LDR_MAX_WORDS  = 1 << LDR_ADDR_W;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StLenHi = 3'd0,
        StLenLo = 3'd1,
        StData  = 3'd2,
        StCsum  = 3'd3,
        StDone  = 3'd4,
        StError = 3'd5
    } state_e;

    // States in which the loader consumes stream bytes.
    function automatic logic accepts_bytes(input state_e s);
        return (s == StLenHi) || (s == StLenLo) || (s == StData) || (s == StCsum);
    endfunction

    // States between the first length byte and a terminal state.
    function automatic logic is_loading(input state_e s);
        return (s == StLenLo) || (s == StData) || (s == StCsum);
    endfunction

endpackage

// File: rtl/icache_boot_loader_byte_packer.sv
// Packs a byte stream MSB-first into DATA_W-bit words and emits a one-cycle
// word_valid pulse, registered, after the last byte of each word.
module icache_boot_loader_byte_packer
    import icache_boot_loader_pkg::*;
#(
    parameter int unsigned DATA_W = LDR_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int unsigned ACC_W = DATA_W - 8;

    logic [1:0]        idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              word_valid_q, word_valid_d;
    logic [DATA_W-1:0] word_q, word_d;

    assign last_byte_o  = (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    always_comb begin
        idx_d        = idx_q;
        acc_d        = acc_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (shift_i) begin
            // Index wraps 3 -> 0 at the word boundary.
            idx_d = idx_q + 2'd1;
            if (last_byte_o) begin
                word_d       = {acc_q, byte_i};
                word_valid_d = 1'b1;
                acc_d        = '0;
            end else begin
                acc_d = {acc_q[ACC_W-9:0], byte_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q        <= '0;
            acc_q        <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

endmodule

// File: rtl/icache_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream, writes
// the packed instructions into the ICache from address 0 and releases the core.
module icache_boot_loader
    import icache_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = LDR_ADDR_W,
    parameter int unsigned DATA_W    = LDR_DATA_W,
    parameter int unsigned MAX_WORDS = LDR_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              ic_we,
    output logic [ADDR_W-1:0] ic_waddr,
    output logic [DATA_W-1:0] ic_wdata,
    output logic              start,
    output logic              busy,
    output logic              err
);

    // One extra bit so a full-size program (2**ADDR_W words) is representable.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;

    logic              accept;
    logic              shift_en;
    logic              last_byte;
    logic              word_valid;
    logic [DATA_W-1:0] word;
    logic [15:0]       len_full;

    assign byte_ready = !rst && accepts_bytes(state_q);
    assign accept     = byte_valid && byte_ready;
    assign shift_en   = accept && (state_q == StData);
    assign len_full   = {len_hi_q, byte_data};

    icache_boot_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk_i        (clk),
        .rst_i        (rst),
        .shift_i      (shift_en),
        .byte_i       (byte_data),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        waddr_d    = waddr_q;
        if (accept) begin
            unique case (state_q)
                StLenHi: begin
                    len_hi_d = byte_data;
                    state_d  = StLenLo;
                end
                StLenLo: begin
                    len_d      = len_full[CNT_W-1:0];
                    word_cnt_d = '0;
                    csum_d     = '0;
                    if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else if ({16'd0, len_full} > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    csum_d = csum_q ^ byte_data;
                    if (last_byte) begin
                        // Address is latched alongside the packed word so both appear together.
                        waddr_d    = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (word_cnt_d == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    state_d = (byte_data == csum_q) ? StDone : StError;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLenHi;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            waddr_q    <= waddr_d;
        end
    end

    assign ic_we    = word_valid;
    assign ic_wdata = word;
    assign ic_waddr = waddr_q;
    assign start    = (state_q == StDone);
    assign err      = (state_q == StError);
    assign busy     = is_loading(state_q);

endmodule
